// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and the instruction RAM.
package imem_boot_loader_pkg;

    localparam int DEF_DEPTH  = 256;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RECV  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [DEF_WORD_W-1:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_byte_assembler.sv
// Packs four serial bytes into one 32-bit word, first byte in the most significant lane.
module imem_byte_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  accept,
    input  logic [7:0]            byte_data,
    output logic [DEF_WORD_W-1:0] word,
    output logic                  word_full
);

    logic [1:0]            byte_cnt;
    logic [DEF_WORD_W-1:0] shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            shift_q  <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
        end else if (accept) begin
            shift_q  <= {shift_q[DEF_WORD_W-9:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // Flags the cycle the fourth byte is taken, so the FSM can move straight to WRITE.
    assign word_full = accept && (byte_cnt == 2'd3);
    assign word      = shift_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Shares the instruction RAM between CPU fetch and a byte-serial boot-load stream;
// the CPU is stalled on NOPs while the RAM is cleared and reloaded.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [31:0]       cpu_pc,
    output logic [WORD_W-1:0] cpu_instr,
    output logic              cpu_stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [ADDR_W-1:0]   word_idx_q;
    logic [ADDR_W:0]     count_q;
    logic                done_q, error_q;

    logic                start_ok;
    logic                last_word;
    logic                accept;
    logic                asm_clr;
    logic                word_full;
    logic [WORD_W-1:0]   asm_word;

    // Only the word-address slice of the PC selects a RAM row.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{cpu_pc[31:ADDR_W+2], cpu_pc[1:0]};

    assign start_ok  = (word_count != '0) && (word_count <= (ADDR_W+1)'(DEPTH));
    assign last_word = ({1'b0, word_idx_q} == (count_q - (ADDR_W+1)'(1)));
    assign accept    = (state_q == ST_RECV) && byte_valid;
    assign asm_clr   = ((state_q == ST_IDLE) && start) || (state_q == ST_WRITE);

    imem_byte_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (asm_clr),
        .accept    (accept),
        .byte_data (byte_data),
        .word      (asm_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && start_ok) state_d = ST_CLEAR;
            ST_CLEAR: if (clr_cnt_q == ADDR_W'(DEPTH-1)) state_d = ST_RECV;
            ST_RECV:  if (word_full) state_d = ST_WRITE;
            ST_WRITE: state_d = last_word ? ST_IDLE : ST_RECV;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_q  <= '0;
            word_idx_q <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    done_q <= 1'b0;
                    if (start_ok) begin
                        count_q    <= word_count;
                        error_q    <= 1'b0;
                        word_idx_q <= '0;
                        clr_cnt_q  <= '0;
                    end else begin
                        error_q <= 1'b1;
                    end
                end
                ST_CLEAR: clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                ST_WRITE: begin
                    if (last_word) done_q     <= 1'b1;
                    else           word_idx_q <= word_idx_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // While loading, fetch sees only NOPs so no partially written word escapes.
    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = cpu_pc[ADDR_W+1:2];
        mem_wdata  = NOP_WORD;
        cpu_instr  = mem_rdata;
        cpu_stall  = 1'b0;
        busy       = 1'b0;
        byte_ready = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q;
                cpu_instr = NOP_WORD;
                cpu_stall = 1'b1;
                busy      = 1'b1;
            end
            ST_RECV: begin
                mem_addr   = word_idx_q;
                byte_ready = 1'b1;
                cpu_instr  = NOP_WORD;
                cpu_stall  = 1'b1;
                busy       = 1'b1;
            end
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = word_idx_q;
                mem_wdata = asm_word;
                cpu_instr = NOP_WORD;
                cpu_stall = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader with a behavioural RAM and load model.
module tb_imem_boot_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  word_count = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic [31:0] cpu_pc = '0;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy, done, error;

    imem_boot_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .cpu_pc     (cpu_pc),
        .cpu_instr  (cpu_instr),
        .cpu_stall  (cpu_stall),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [DEPTH];
    logic [39:0] wlog [$];
    logic [31:0] model_mem [DEPTH];
    logic [7:0]  bytes_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          nop_viol = 0;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
        end
    end

    always @(negedge clk) begin
        if ((busy && (cpu_instr !== 32'h0)) || (cpu_stall !== busy)) nop_viol++;
    end

    function automatic logic [31:0] pat(input int a);
        return (32'(a) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_bytes(input int nbytes);
        bytes_q.delete();
        for (int i = 0; i < nbytes; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // mode 0: back-to-back bytes, 1: valid every other cycle, 2: random gaps
    task automatic do_load(input int n, input int mode, input int abort_k, input bit inject,
                           output int cyc);
        int k;
        int limit;
        bit acc;
        k = 0;
        limit = DEPTH + 40 * n + 100;
        nop_viol = 0;
        @(negedge clk);
        start = 1'b1;
        word_count = 9'(n);
        byte_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wlog.delete();
        cyc = 0;
        while (busy && cyc < limit) begin
            @(negedge clk);
            if (inject && k == 2) begin
                start = 1'b1;
                word_count = 9'd5;
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       byte_valid = 1'b1;
                1:       byte_valid = (cyc % 2 == 0);
                default: byte_valid = 1'($urandom_range(0, 1));
            endcase
            byte_data = (k < bytes_q.size()) ? bytes_q[k] : 8'($urandom);
            #1 acc = byte_valid && byte_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) k++;
            if (abort_k >= 0 && k == abort_k) break;
        end
        start = 1'b0;
        byte_valid = 1'b0;
        if (abort_k < 0) check("load_timeout_busy", 64'(busy), 64'd0);
    endtask

    task automatic verify_load(input int n);
        int first_bad;
        logic [39:0] exp_e;
        int a;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        for (int w = 0; w < n; w++)
            model_mem[w] = (32'(bytes_q[4*w]) << 24) | (32'(bytes_q[4*w+1]) << 16) |
                           (32'(bytes_q[4*w+2]) << 8) | 32'(bytes_q[4*w+3]);
        check("write_count", 64'(wlog.size()), 64'(DEPTH + n));
        first_bad = -1;
        for (int i = 0; i < wlog.size() && i < DEPTH + n; i++) begin
            if (i < DEPTH) exp_e = {8'(i), 32'h0};
            else           exp_e = {8'(i - DEPTH), model_mem[i - DEPTH]};
            if (wlog[i] !== exp_e && first_bad < 0) first_bad = i;
        end
        check("write_seq_first_bad_idx", 64'(first_bad), 64'hFFFF_FFFF_FFFF_FFFF);
        check("done_after_load", 64'(done), 64'd1);
        check("error_after_load", 64'(error), 64'd0);
        check("stall_after_load", 64'(cpu_stall), 64'd0);
        check("nop_while_busy", 64'(nop_viol), 64'd0);
        for (int j = 0; j < 6; j++) begin
            a = (j < 4) ? j : ((j == 4) ? (n < DEPTH ? n : DEPTH - 1) : $urandom_range(0, DEPTH - 1));
            @(negedge clk);
            cpu_pc = ($urandom & 32'hFFFF_FC00) | (32'(a) << 2) | 32'($urandom_range(0, 3));
            #1;
            check("fetch_addr", 64'(mem_addr), 64'(a));
            check("fetch_instr", 64'(cpu_instr), 64'(model_mem[a]));
        end
    endtask

    task automatic illegal_start(input logic [8:0] wc);
        @(negedge clk);
        start = 1'b1;
        word_count = wc;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("illegal_error", 64'(error), 64'd1);
        check("illegal_done_cleared", 64'(done), 64'd0);
        check("illegal_busy", 64'(busy), 64'd0);
        wlog.delete();
        repeat (3) @(posedge clk);
        #1;
        check("illegal_no_writes", 64'(wlog.size()), 64'd0);
        check("illegal_still_idle", 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [7:0]  exp_addr;
        logic [31:0] exp_instr;
    } fetch_vec_t;

    initial begin
        fetch_vec_t vecs [6];
        int cyc;
        int n;
        int mode;

        for (int i = 0; i < DEPTH; i++) ram[i] = pat(i);
        vecs[0] = '{32'h0000_0008, 8'd2,   pat(2)};
        vecs[1] = '{32'h0000_0007, 8'd1,   pat(1)};
        vecs[2] = '{32'h0000_03FF, 8'd255, pat(255)};
        vecs[3] = '{32'h0000_0400, 8'd0,   pat(0)};
        vecs[4] = '{32'hFFFF_FFFD, 8'd255, pat(255)};
        vecs[5] = '{32'h1234_5290, 8'd164, pat(164)};

        #3;
        check("reset_byte_ready", 64'(byte_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_stall", 64'(cpu_stall), 64'd0);
        check("reset_mem_we", 64'(mem_we), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_error", 64'(error), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cpu_pc = vecs[i].pc;
            #1;
            check("idle_fetch_addr", 64'(mem_addr), 64'(vecs[i].exp_addr));
            check("idle_fetch_instr", 64'(cpu_instr), 64'(vecs[i].exp_instr));
            check("idle_no_stall", 64'(cpu_stall), 64'd0);
        end

        bytes_q = '{8'h20, 8'h01, 8'h03, 8'hE8, 8'h20, 8'h02, 8'h00, 8'hC8};
        do_load(2, 0, -1, 1'b0, cyc);
        check("load2_cycles", 64'(cyc), 64'd266);
        check("load2_word0", 64'(wlog.size() > 256 ? wlog[256] : 40'h0), {24'h0, 8'd0, 32'h2001_03E8});
        check("load2_word1", 64'(wlog.size() > 257 ? wlog[257] : 40'h0), {24'h0, 8'd1, 32'h2002_00C8});
        verify_load(2);

        illegal_start(9'd0);
        illegal_start(9'd257);

        fill_bytes(8);
        do_load(2, 0, -1, 1'b1, cyc);
        check("busy_start_cycles", 64'(cyc), 64'd266);
        verify_load(2);

        bytes_q = '{8'h20, 8'h01, 8'h03, 8'hE8, 8'h20, 8'h02, 8'h00, 8'hC8};
        do_load(2, 1, -1, 1'b0, cyc);
        check("gap_slower", 64'(cyc > 266), 64'd1);
        verify_load(2);

        fill_bytes(8);
        do_load(2, 0, 6, 1'b0, cyc);
        check("pre_abort_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_byte_ready", 64'(byte_ready), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_stall", 64'(cpu_stall), 64'd0);
        check("abort_mem_we", 64'(mem_we), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_bytes(4);
        do_load(1, 0, -1, 1'b0, cyc);
        check("after_abort_cycles", 64'(cyc), 64'd261);
        verify_load(1);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 8);
            mode = $urandom_range(0, 2);
            fill_bytes(4 * n);
            do_load(n, mode, -1, 1'b0, cyc);
            if (mode == 0) check("rand_cycles", 64'(cyc), 64'(DEPTH + 5 * n));
            verify_load(n);
        end

        fill_bytes(4 * DEPTH);
        do_load(DEPTH, 0, -1, 1'b0, cyc);
        check("full_cycles", 64'(cyc), 64'(DEPTH + 5 * DEPTH));
        verify_load(DEPTH);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
